// File: rtl/probe_capture_pkg.sv
// Shared types and helpers for the probe capture buffer.
// State encoding, address width and bytes-per-word helpers.
package probe_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    READ
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/probe_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata write side, re/raddr/rdata read side.
module capture_ram
  import probe_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [addr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [addr_w(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/probe_capture_reader.sv
// Trigger-capture buffer: circular sampling, freeze around trigger, byte readout.
// Ports: clk/rst, probe_data, trig_in, arm, busy, done, m_data/m_valid/m_ready/m_last.
module probe_capture_reader
  import probe_capture_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] probe_data,
  input  logic              trig_in,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int AW    = addr_w(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int BW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int POSTN = DEPTH - PRE_TRIG - 1;

  localparam logic [CW-1:0] PRE_END =
    CW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [CW-1:0] POST_END =
    CW'((POSTN > 0) ? POSTN - 1 : 0);
  localparam logic [CW-1:0] WORDS  = CW'(DEPTH);
  localparam logic [AW-1:0] PRE_OFS = AW'(PRE_TRIG);
  localparam logic [BW-1:0] LAST_B  = BW'(BPW - 1);

  state_t state, nstate;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              we;
  logic              trig_hit;

  logic [DATA_W-1:0] rdata;
  logic [CW-1:0]     rd_left;
  logic [CW-1:0]     ld_cnt;
  logic              nv;
  logic              sv;
  logic [BW-1:0]     bidx;
  logic [DATA_W-1:0] sh;
  logic              xfer;
  logic              load;
  logic              rd_en;

  capture_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(probe_data),
    .re   (rd_en),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // Output stage: sh holds the word being serialised, the RAM output
  // register (flagged by nv) holds the prefetched next word.
  assign m_valid = sv;
  assign m_data  = sh[DATA_W-1 -: 8];
  assign m_last  = sv && (bidx == LAST_B) && (ld_cnt == WORDS);
  assign xfer    = m_valid && m_ready;
  assign done    = xfer && m_last;
  assign busy    = (state != IDLE);

  assign load  = nv && (!sv || (xfer && (bidx == LAST_B)));
  assign rd_en = (state == READ) && (rd_left != '0) && (!nv || load);

  always_comb begin
    nstate   = state;
    we       = 1'b0;
    trig_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) nstate = (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
      end
      PRE: begin
        we = 1'b1;
        if (cnt == PRE_END) nstate = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        we = 1'b1;
        if (trig_in) begin
          trig_hit = 1'b1;
          nstate   = (POSTN == 0) ? READ : POST;
        end
      end
      POST: begin
        we = 1'b1;
        if (cnt == POST_END) nstate = READ;
      end
      READ: begin
        if (done) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && arm) begin
        wr_ptr <= '0;
        cnt    <= '0;
      end
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt    <= cnt + 1'b1;
      end
      // Window start sits PRE_TRIG slots behind the trigger sample.
      if (trig_hit) begin
        rd_ptr <= wr_ptr - PRE_OFS;
        cnt    <= '0;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != READ) begin
      rd_left <= WORDS;
      ld_cnt  <= '0;
      nv      <= 1'b0;
      sv      <= 1'b0;
      bidx    <= '0;
      sh      <= '0;
    end else begin
      if (rd_en) begin
        rd_left <= rd_left - 1'b1;
        nv      <= 1'b1;
      end else if (load) begin
        nv <= 1'b0;
      end
      if (load) begin
        sh     <= rdata;
        sv     <= 1'b1;
        bidx   <= '0;
        ld_cnt <= ld_cnt + 1'b1;
      end else if (xfer) begin
        sh   <= sh << 8;
        bidx <= bidx + 1'b1;
        if (bidx == LAST_B) sv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_probe_capture_reader.sv
// Self-checking bench for probe_capture_reader (DATA_W=16, DEPTH=16, PRE_TRIG=4).
// Reference model predicts window bytes and busy/done from the capture rules.
module tb_probe_capture_reader;

  localparam int DW    = 16;
  localparam int DEP   = 16;
  localparam int PT    = 4;
  localparam int POSTN = DEP - PT - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probe_data;
  logic          trig_in;
  logic          arm;
  logic          busy;
  logic          done;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  probe_capture_reader #(
    .DATA_W  (DW),
    .DEPTH   (DEP),
    .PRE_TRIG(PT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .probe_data(probe_data),
    .trig_in   (trig_in),
    .arm       (arm),
    .busy      (busy),
    .done      (done),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  int         ncomp = 0;
  int         nfail = 0;
  bit         chk_en = 0;
  bit         rdy_rand = 0;
  int         mode = 0;
  int         nw = 0;
  bit         fin = 0;
  int         cyc = 0;
  int         trig_cyc = 0;
  int         ndone = 0;
  logic [7:0] expq[$];
  logic [7:0] got[$];
  logic [15:0] base;

  bit         prev_v = 0;
  bit         prev_r = 0;
  bit         prev_rst = 1;
  logic [7:0] prev_d = '0;
  bit         prev_l = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    probe_data = probe_data + 16'd1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Model: 0 idle, 1 capturing before trigger, 2 trigger taken.
  always @(posedge clk) begin
    logic [15:0] w;
    cyc++;
    if (rst) begin
      mode = 0;
      fin = 0;
      expq.delete();
    end else if (fin) begin
      mode = 0;
      fin = 0;
    end else if (mode == 0) begin
      if (arm) begin
        mode = 1;
        nw = 0;
      end
    end else if (mode == 1) begin
      if (nw >= PT && trig_in) begin
        for (int i = 0; i < DEP; i++) begin
          w = probe_data - 16'(PT) + 16'(i);
          expq.push_back(w[15:8]);
          expq.push_back(w[7:0]);
        end
        trig_cyc = cyc;
        mode = 2;
      end
      nw++;
    end
  end

  always @(negedge clk) begin
    bit hs;
    if (chk_en) begin
      hs = m_valid && m_ready;
      chk("busy", busy, (mode != 0));
      if (!rst) begin
        if (prev_v && !prev_r && !prev_rst) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, prev_d);
          chk("hold_last", m_last, prev_l);
        end
        if (m_valid && !prev_v)
          chk("first_valid_latency", cyc - trig_cyc, POSTN + 2);
        if (m_valid && expq.size() == 0)
          chk("spurious_valid", m_valid, 0);
        chk("done", done, (hs && expq.size() == 1));
        if (done) ndone++;
        if (hs && expq.size() > 0) begin
          chk("data", m_data, expq[0]);
          chk("last", m_last, (expq.size() == 1));
          got.push_back(m_data);
          void'(expq.pop_front());
          if (expq.size() == 0) fin = 1;
        end
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
      prev_l = m_last;
      prev_rst = rst;
    end
  end

  task automatic arm_trig(input int td, input bit noise);
    logic [15:0] a;
    got.delete();
    ndone = 0;
    a = probe_data;
    base = a;
    arm = 1'b1;
    if (td == 0) trig_in = 1'b1;
    step();
    arm = 1'b0;
    if (noise) begin
      step();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
    end
    if (td != 0)
      for (int i = 0; i < 5000 && probe_data != a + 16'(td); i++) step();
    trig_in = 1'b1;
    for (int i = 0; i < 200 && mode != 2; i++) step();
    trig_in = 1'b0;
    if (noise) begin
      repeat (3) step();
      arm = 1'b1;
      step();
      arm = 1'b0;
      for (int i = 0; i < 200 && got.size() < 3; i++) step();
      arm = 1'b1;
      step();
      arm = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while (mode != 0 && i < 4000) begin
      step();
      i++;
    end
    ncomp++;
    if (mode != 0) begin
      nfail++;
      $display("FAIL %s: stream did not finish within 4000 cycles", nm);
      rst = 1'b1;
      step();
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    trig_in = 1'b0;
    m_ready = 1'b1;
    probe_data = '0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;
    chk_en = 1;

    for (int i = 0; i < 100 && probe_data != 16'd10; i++) step();
    arm_trig(90, 0);
    wait_idle("basic");
    chk("basic_len", got.size(), 32);
    chk("basic_b0", got[0], 8'h00);
    chk("basic_b1", got[1], 8'h60);
    chk("basic_b31", got[31], 8'h6F);
    chk("basic_done", ndone, 1);

    rdy_rand = 1;
    arm_trig(90, 0);
    wait_idle("backpressure");
    chk("bp_len", got.size(), 32);
    chk("bp_first", {got[0], got[1]}, base + 16'd86);
    chk("bp_done", ndone, 1);

    rdy_rand = 0;
    arm_trig(0, 0);
    wait_idle("early");
    chk("early_first", {got[0], got[1]}, base + 16'd1);
    chk("early_len", got.size(), 32);

    arm_trig(1000, 0);
    wait_idle("wrap");
    chk("wrap_first", {got[0], got[1]}, base + 16'd996);
    chk("wrap_last", {got[30], got[31]}, base + 16'd1011);

    rdy_rand = 1;
    arm_trig(30, 0);
    for (int i = 0; i < 500 && got.size() < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", ndone, 0);
    arm_trig(50, 0);
    wait_idle("after_reset");
    chk("after_rst_len", got.size(), 32);
    chk("after_rst_first", {got[0], got[1]}, base + 16'd46);

    arm_trig(20, 1);
    wait_idle("ignored");
    chk("ign_len", got.size(), 32);
    chk("ign_first", {got[0], got[1]}, base + 16'd16);
    chk("ign_done", ndone, 1);

    for (int k = 0; k < 5; k++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      arm_trig($urandom_range(0, 400), 0);
      wait_idle("random");
      chk("rand_len", got.size(), 32);
      chk("rand_done", ndone, 1);
      repeat ($urandom_range(0, 5)) step();
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/probe_capture_reader.md
# probe_capture_reader

On-chip trigger-capture buffer: samples a probe word every clock into a circular RAM, freezes it around a trigger event, then reads the window back out as a byte stream (valid/ready) for the UDP transmit payload path. It is the readout counterpart to the probe-watching debug cores in the UDP example design. Captured data leaves over the network instead of JTAG.

## Interface
- DATA_W, 32, probe word width in bits; multiple of 8
- DEPTH, 256, samples per capture window; power of 2, ≥ 4
- PRE_TRIG, 64, samples kept before the trigger sample; 0 ≤ PRE_TRIG < DEPTH
- clk  input  1  sole clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- probe_data  input  DATA_W  sampled every cycle while capturing
- trig_in  input  1  level trigger; qualified only in WAIT_TRIG
- arm  input  1  one-cycle start request; honoured only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the final byte is accepted
- m_data  output  8  stream byte
- m_valid  output  1  stream byte valid
- m_ready  input  1  downstream accept
- m_last  output  1  high with the final byte of the window

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, READ.
- IDLE: no writes. arm=1 clears wr_ptr and the sample count, then goes to PRE.
- PRE: writes probe_data at wr_ptr and increments it mod DEPTH each cycle. Moves to WAIT_TRIG after PRE_TRIG writes. With PRE_TRIG=0, PRE lasts 0 cycles and arm goes directly to WAIT_TRIG. trig_in is ignored in PRE.
- WAIT_TRIG: writes continue circularly. If trig_in=1, the sample written that cycle is the trigger sample at address T. Latch start = (T − PRE_TRIG) mod DEPTH and go to POST.
- POST: writes DEPTH−PRE_TRIG−1 further samples, then goes to READ. If that count is 0, go directly to READ.
- READ: read DEPTH words starting at start, ascending mod DEPTH. Each word is emitted as DATA_W/8 bytes, MSB first. Total length is DEPTH·DATA_W/8 bytes.
- m_last accompanies the final byte. The handshake on that byte pulses done, and the block returns to IDLE on the same edge.
- Handshake rules:
  - A byte transfers on a cycle with m_valid & m_ready.
  - Once m_valid is asserted, m_data and m_last hold and m_valid stays high until the transfer.
  - No byte is dropped or duplicated under any m_ready pattern.
- arm outside IDLE is ignored. trig_in outside WAIT_TRIG is ignored.
- Any cycle with rst=1 forces IDLE and zeroes all pointers and outputs, including in mid-capture or mid-stream. RAM contents are don't-care after reset. An aborted stream gets no m_last and no done.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0.
- busy rises the cycle after arm is sampled in IDLE. It falls the cycle after the final handshake.
- RAM read latency is 1 cycle. First m_valid appears exactly 2 cycles after entering READ.
- Sustained throughput is 1 byte/cycle while m_ready=1, with no bubbles at word boundaries. Prefetch the next word during the current word's bytes; use a 2-entry word buffer or a skid buffer.
- The write in the cycle trig_in is seen belongs to the trigger sample. The last POST write occurs on the cycle before READ is entered.
- Pointer arithmetic is log2(DEPTH) bits and wraps naturally; there is no separate full flag.

## Structure
- Package probe_capture_pkg holds:
  - state enum (IDLE, PRE, WAIT_TRIG, POST, READ)
  - ADDR_W = $clog2(DEPTH) helper
  - BYTES_PER_WORD function
- Sub-module capture_ram: simple dual-port RAM, 1 write port and 1 read port, registered read, DEPTH × DATA_W. It maps to block RAM.
- Top level holds the FSM, pointers, sample and byte counters, and the output serializer/skid.

## Test plan
Bench config for all scenarios: DATA_W=16, DEPTH=16, PRE_TRIG=4; probe_data is a free-running 16-bit counter.
- Basic: arm at count 10; trig_in at count 100 → 32 bytes, words 96..111. First bytes 0x00, 0x60. Last byte 0x6F with m_last=1. done pulses once.
- Backpressure: same stimulus with m_ready pseudo-random (~50%) → identical 32-byte sequence. m_data and m_last stay stable while m_valid & !m_ready.
- Early trigger: trig_in held high from arm onward → the trigger is taken on the first WAIT_TRIG cycle. Stream starts at the first sample written after arm.
- Wrap-around: trigger 1000 cycles after arm → window is trigger−4 .. trigger+11, correctly ordered across the RAM wrap.
- Reset mid-READ: assert rst after 7 bytes → next cycle m_valid=0 and busy=0, with no done. A fresh arm/trigger then produces a complete, correct stream.
- Ignored inputs: arm pulses during POST and READ, and trig_in pulses during PRE, produce no change to the captured window or byte count.
